// File: rtl/wb_arbiter_n.sv
// wb_arbiter_n: writeback arbiter. Each function-unit channel feeds a small
// FIFO; up to NUM_WB non-empty FIFOs are drained per cycle onto registered
// writeback ports. Compile-time option WB_ARB_RR_EN selects a round-robin
// search order; without it, channel 0 always has highest priority.
module wb_arbiter_n #(
  parameter int NUM_CH               = 2,
  parameter int NUM_WB               = 1,
  parameter int FIFO_DEPTH           = 2,
  parameter int XLEN                 = 64,
  parameter int PHY_REG_ADDR_WIDTH   = 6,
  parameter int ROB_INDEX_WIDTH      = 4,
  parameter int EXCEPTION_CODE_WIDTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush_i,
  input  logic [NUM_CH-1:0]                      ch_valid_i,
  output logic [NUM_CH-1:0]                      ch_ready_o,
  input  logic [NUM_CH*ROB_INDEX_WIDTH-1:0]      ch_rob_index_i,
  input  logic [NUM_CH-1:0]                      ch_rd_valid_i,
  input  logic [NUM_CH*PHY_REG_ADDR_WIDTH-1:0]   ch_rd_addr_i,
  input  logic [NUM_CH*XLEN-1:0]                 ch_data_i,
  input  logic [NUM_CH-1:0]                      ch_exp_i,
  input  logic [NUM_CH*EXCEPTION_CODE_WIDTH-1:0] ch_ecause_i,
  output logic [NUM_WB-1:0]                      wb_valid_o,
  output logic [NUM_WB*ROB_INDEX_WIDTH-1:0]      wb_rob_index_o,
  output logic [NUM_WB-1:0]                      wb_rd_valid_o,
  output logic [NUM_WB*PHY_REG_ADDR_WIDTH-1:0]   wb_rd_addr_o,
  output logic [NUM_WB*XLEN-1:0]                 wb_data_o,
  output logic [NUM_WB-1:0]                      wb_exp_o,
  output logic [NUM_WB*EXCEPTION_CODE_WIDTH-1:0] wb_ecause_o
);

  localparam int RI = ROB_INDEX_WIDTH;
  localparam int PA = PHY_REG_ADDR_WIDTH;
  localparam int EC = EXCEPTION_CODE_WIDTH;

  // Record layout, MSB to LSB: {rob_index, rd_valid, rd_addr, data, exp, ecause}
  localparam int REC_W    = RI + 1 + PA + XLEN + 1 + EC;
  localparam int EXP_LSB  = EC;
  localparam int DATA_LSB = EC + 1;
  localparam int RDA_LSB  = DATA_LSB + XLEN;
  localparam int RDV_LSB  = RDA_LSB + PA;
  localparam int ROB_LSB  = RDV_LSB + 1;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CH_W  = $clog2(NUM_CH);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [REC_W-1:0]  head_rec [NUM_CH];
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] grant;
  logic [NUM_WB-1:0] port_vld;
  logic [REC_W-1:0]  port_rec [NUM_WB];
  logic [CH_W-1:0]   search_base;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [REC_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [REC_W-1:0] in_rec;
    logic             push;
    logic             pop;

    assign in_rec = {ch_rob_index_i[gi*RI +: RI], ch_rd_valid_i[gi],
                     ch_rd_addr_i[gi*PA +: PA], ch_data_i[gi*XLEN +: XLEN],
                     ch_exp_i[gi], ch_ecause_i[gi*EC +: EC]};

    // Ready comes from the registered count only, so a full FIFO never
    // accepts in the cycle it is popped.
    assign ch_ready_o[gi] = (count_reg != CNT_FULL) && !flush_i;
    assign push           = ch_valid_i[gi] && ch_ready_o[gi];
    assign pop            = grant[gi];
    assign fifo_empty[gi] = (count_reg == '0);
    assign head_rec[gi]   = mem_reg[rd_ptr_reg];

    // Record storage, written at the tail on enqueue
    always_ff @(posedge clk) begin
      if (push) mem_reg[wr_ptr_reg] <= in_rec;
    end

    // Pointers and occupancy; flush and reset discard everything buffered
    always_ff @(posedge clk) begin
      if (reset || flush_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
        else if (!push && pop) count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

`ifdef WB_ARB_RR_EN
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  logic [CH_W-1:0] rr_ptr_reg;
  logic [CH_W-1:0] last_sel;
  assign search_base = rr_ptr_reg;

  // Round-robin pointer moves past the last channel granted this cycle
  always_ff @(posedge clk) begin
    if (reset || flush_i)
      rr_ptr_reg <= '0;
    else if (|grant)
      rr_ptr_reg <= (last_sel == CH_LAST) ? '0 : last_sel + CH_W'(1);
  end
`else
  assign search_base = '0;
`endif

  // Walk channels in search order, handing the k-th non-empty one to port k
  always_comb begin : arb
    logic [CH_W-1:0] idx;
    int              n_sel;
    grant    = '0;
    port_vld = '0;
    n_sel    = 0;
    idx      = '0;
    for (int k = 0; k < NUM_WB; k++) port_rec[k] = '0;
`ifdef WB_ARB_RR_EN
    last_sel = rr_ptr_reg;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(search_base) + i) % NUM_CH);
      if (!fifo_empty[idx] && (n_sel < NUM_WB)) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < NUM_WB; k++) begin
          if (k == n_sel) begin
            port_vld[k] = 1'b1;
            port_rec[k] = head_rec[idx];
          end
        end
        n_sel = n_sel + 1;
`ifdef WB_ARB_RR_EN
        last_sel = idx;
`endif
      end
    end
  end

  // Writeback port registers, loaded from the heads popped this cycle
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wb_valid_o     <= '0;
      wb_rob_index_o <= '0;
      wb_rd_valid_o  <= '0;
      wb_rd_addr_o   <= '0;
      wb_data_o      <= '0;
      wb_exp_o       <= '0;
      wb_ecause_o    <= '0;
    end else begin
      for (int k = 0; k < NUM_WB; k++) begin
        wb_valid_o[k] <= port_vld[k];
        if (port_vld[k]) begin
          wb_rob_index_o[k*RI +: RI]     <= port_rec[k][ROB_LSB +: RI];
          wb_rd_valid_o[k]               <= port_rec[k][RDV_LSB];
          wb_rd_addr_o[k*PA +: PA]       <= port_rec[k][RDA_LSB +: PA];
          wb_data_o[k*XLEN +: XLEN]      <= port_rec[k][DATA_LSB +: XLEN];
          wb_exp_o[k]                    <= port_rec[k][EXP_LSB];
          wb_ecause_o[k*EC +: EC]        <= port_rec[k][EC-1:0];
        end
      end
    end
  end

endmodule

// File: doc/wb_arbiter_n.md
# wb_arbiter_n

Parametrised writeback arbiter between the function units and the ROB/physical register file. It accepts completion records from NUM_CH function-unit channels (ALU, LSU, CSR, further pipes), buffers each channel in a small FIFO, and drains up to NUM_WB records per cycle onto registered writeback ports. It removes the restriction that at most one ALU and one LSU writeback may arrive per cycle, and it adds backpressure to the units.

## Interface
Parameters:
- NUM_CH, 2, number of function-unit channels (≥2)
- NUM_WB, 1, number of writeback ports (1 ≤ NUM_WB ≤ NUM_CH)
- FIFO_DEPTH, 2, entries per channel FIFO (≥1)
- XLEN, 64, data width
- PHY_REG_ADDR_WIDTH, 6, physical rd address width
- ROB_INDEX_WIDTH, 4, ROB line index width
- EXCEPTION_CODE_WIDTH, 4, ecause width

Ports (channel/port c occupies slice [c*W +: W] of its vector):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush (trap)
- ch_valid_i  in  NUM_CH  record valid
- ch_ready_o  out  NUM_CH  channel can accept
- ch_rob_index_i  in  NUM_CH*ROB_INDEX_WIDTH  ROB line
- ch_rd_valid_i  in  NUM_CH  record writes rd
- ch_rd_addr_i  in  NUM_CH*PHY_REG_ADDR_WIDTH  physical rd
- ch_data_i  in  NUM_CH*XLEN  result
- ch_exp_i  in  NUM_CH  exception flag
- ch_ecause_i  in  NUM_CH*EXCEPTION_CODE_WIDTH  exception cause
- wb_valid_o  out  NUM_WB  port carries a record (ROB done)
- wb_rob_index_o  out  NUM_WB*ROB_INDEX_WIDTH
- wb_rd_valid_o  out  NUM_WB  PRF write enable (qualified by wb_valid_o)
- wb_rd_addr_o  out  NUM_WB*PHY_REG_ADDR_WIDTH
- wb_data_o  out  NUM_WB*XLEN
- wb_exp_o  out  NUM_WB
- wb_ecause_o  out  NUM_WB*EXCEPTION_CODE_WIDTH

## Operation
- Per channel: FIFO of FIFO_DEPTH records {rob_index, rd_valid, rd_addr, data, exp, ecause}, with an occupancy counter of width $clog2(FIFO_DEPTH+1).
- ch_ready_o[c] = (count[c] != FIFO_DEPTH) & !flush_i. Ready depends only on state and flush_i, never on ch_valid_i or on the grants.
- Enqueue on ch_valid_i[c] & ch_ready_o[c].
- A full FIFO does not accept in the same cycle it is popped; ready is derived from the registered count only.
- Arbitration each cycle: among non-empty FIFOs, select up to NUM_WB channels in search order. The k-th selected channel drives port k; the remaining ports are invalid. Selected heads are popped.
- Output registers: wb_* are loaded from the popped heads at the clock edge. wb_valid_o[k] = 0 when port k received no record.
- The ROB/PRF always accept; there is no output backpressure.
- Order within a channel is preserved. No ordering is guaranteed across channels.
- flush_i: at the clock edge, all counts and pointers clear, wb_valid_o clears, and the RR pointer resets to 0. Flush wins over enqueue and pop in the same cycle, and records presented that cycle are dropped.
- reset: same effect as flush. All outputs reset to 0, and ch_ready_o is all-ones one cycle after reset is released.

## Timing
- Accept at edge t → FIFO non-empty during cycle t+1 → wb_valid_o high during cycle t+2 when granted. Minimum latency is 2 cycles.
- Throughput: NUM_WB records/cycle total. Each channel drains at most 1 record/cycle.
- A single channel sustains 1 record/cycle when FIFO_DEPTH ≥ 2. With FIFO_DEPTH = 1 it sustains 1 record per 2 cycles.
- Pointer wrap: the RR pointer advances modulo NUM_CH. It is unchanged in cycles with no grant.
- Data and addresses are passed unchanged; no arithmetic is performed on the payload.

## Configuration
- WB_ARB_RR_EN defined: round-robin. Search order starts at pointer p and wraps modulo NUM_CH. After a cycle with grants, p = (last selected channel + 1) mod NUM_CH.
- WB_ARB_RR_EN undefined: fixed priority. Search order is always channel 0 → NUM_CH-1, there is no pointer register, and starvation is permitted.

## Test plan
- Reset/idle: assert reset 2 cycles → all wb_valid_o = 0. ch_ready_o = all-ones after release.
- Single record: NUM_CH=2, NUM_WB=1; ch0 sends rob 3, rd 0x21, data 0xDEAD at edge t → wb_valid_o=1, rob 3, rd 0x21, data 0xDEAD in cycle t+2 only.
- Conflict, RR: ch0 and ch1 both send continuously with NUM_WB=1 and RR enabled → ports alternate ch0, ch1, ch0… Without the macro, ch0 always wins and ch1 ready drops after FIFO_DEPTH accepts.
- Dual port: NUM_CH=3, NUM_WB=2, all three valid in the same cycle, pointer 0 → port0 = ch0, port1 = ch1 two cycles later. ch2 appears one cycle after that on port0.
- Backpressure/full: FIFO_DEPTH=2, hold ch1 ungranted (fixed priority, ch0 saturating) → ch1 accepts exactly 2 records, then ch1_ready=0. No record is lost, and ch1 records exit in order once ch0 stops.
- Flush: 4 records buffered, assert flush_i for one cycle with ch0 valid → next cycle all counts 0 and wb_valid_o = 0. The flush-cycle input never appears on any port.
